// File: rtl/bin_to_gray_conv_pkg.sv
// bin_to_gray_conv_pkg: shared configuration for the binary-to-Gray converter.
package bin_to_gray_conv_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
endpackage

// File: rtl/bin_to_gray_conv_comb.sv
// bin_to_gray_comb: stateless XOR network mapping a binary word to reflected Gray code.
module bin_to_gray_comb #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] bin_i,
    output logic [DATA_WIDTH-1:0] gray_o
);
    always_comb begin
        gray_o[DATA_WIDTH-1] = bin_i[DATA_WIDTH-1];
        for (int i = 0; i < DATA_WIDTH - 1; i++) gray_o[i] = bin_i[i] ^ bin_i[i+1];
    end
endmodule

// File: rtl/bin_to_gray_conv.sv
// bin_to_gray_conv: Gray encoder with a combinational output and an enabled, async-reset registered copy.
module bin_to_gray_conv
    import bin_to_gray_conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  en_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic [DATA_WIDTH-1:0] data_q_o
);
    logic [DATA_WIDTH-1:0] gray;
    logic [DATA_WIDTH-1:0] gray_d;
    logic [DATA_WIDTH-1:0] gray_q;

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("bin_to_gray_conv: DATA_WIDTH must be at least 1");
    end

    bin_to_gray_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
        .bin_i (data_in_i),
        .gray_o(gray)
    );

    always_comb begin
        gray_d = en_i ? gray : gray_q;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) gray_q <= '0;
        else          gray_q <= gray_d;
    end

    assign data_out_o = gray;
    assign data_q_o   = gray_q;
endmodule

// File: tb/tb_bin_to_gray_conv.sv
// tb_bin_to_gray_conv: directed and randomized checks of both Gray outputs against an arithmetic model.
module tb_bin_to_gray_conv;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        en;
    logic [10:0] din;
    logic [10:0] dout;
    logic [10:0] dq;
    logic        din1;
    logic        dout1;
    logic        dq1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bin_to_gray_conv #(.DATA_WIDTH(11)) dut (
        .clk_i     (clk),
        .arst_ni   (arst_n),
        .data_in_i (din),
        .en_i      (en),
        .data_out_o(dout),
        .data_q_o  (dq)
    );

    bin_to_gray_conv #(.DATA_WIDTH(1)) dut1 (
        .clk_i     (clk),
        .arst_ni   (arst_n),
        .data_in_i (din1),
        .en_i      (en),
        .data_out_o(dout1),
        .data_q_o  (dq1)
    );

    function automatic logic [10:0] gray(input logic [10:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [10:0] dir_in [6];
        logic [10:0] dir_out[6];
        logic [10:0] exp_q;
        logic [10:0] prev;
        int          pass;
        dir_in  = '{11'h000, 11'h001, 11'h002, 11'h555, 11'h400, 11'h7FF};
        dir_out = '{11'h000, 11'h001, 11'h003, 11'h7FF, 11'h600, 11'h400};
        arst_n = 1'b0;
        en     = 1'b0;
        din    = 11'h000;
        din1   = 1'b0;
        #1;
        check("reset_q", dq, 11'h000);
        check("reset_q_w1", {10'b0, dq1}, 11'h000);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = dir_in[i];
            #1;
            check("directed", dout, dir_out[i]);
        end
        pass = 0;
        for (int i = 0; i < 2048; i++) begin
            din = 11'($urandom_range(0, 2047));
            #1;
            if (dout === gray(din)) pass++;
            check("random_conv", dout, gray(din));
        end
        $display("data conversion %0d/2048", pass);
        din = 11'h000;
        #1;
        prev = dout;
        for (int i = 1; i <= 2048; i++) begin
            din = 11'(i % 2048);
            #1;
            check("hamming", 11'($countones(dout ^ prev)), 11'd1);
            prev = dout;
        end
        @(negedge clk);
        en  = 1'b1;
        din = 11'h3A5;
        @(posedge clk);
        #1;
        check("load_3a5", dq, 11'h277);
        en  = 1'b0;
        din = 11'h001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold_q", dq, 11'h277);
            check("hold_out", dout, 11'h001);
        end
        @(negedge clk);
        #2;
        din    = 11'h2C3;
        arst_n = 1'b0;
        #1;
        check("async_rst_q", dq, 11'h000);
        check("rst_out", dout, gray(11'h2C3));
        en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_en", dq, 11'h000);
        @(negedge clk);
        arst_n = 1'b1;
        din    = 11'h400;
        @(posedge clk);
        #1;
        check("post_rst_load", dq, 11'h600);
        exp_q = dq;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            din = 11'($urandom_range(0, 2047));
            en  = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (en) exp_q = gray(din);
            #1;
            check("rand_reg", dq, exp_q);
        end
        @(negedge clk);
        en   = 1'b1;
        din1 = 1'b0;
        #1;
        check("w1_out0", {10'b0, dout1}, 11'd0);
        @(posedge clk);
        #1;
        check("w1_q0", {10'b0, dq1}, 11'd0);
        @(negedge clk);
        din1 = 1'b1;
        #1;
        check("w1_out1", {10'b0, dout1}, 11'd1);
        @(posedge clk);
        #1;
        check("w1_q1", {10'b0, dq1}, 11'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin_to_gray_conv.md
# bin_to_gray_conv

Converts a DATA_WIDTH-bit binary word to reflected Gray code. It has two outputs: a zero-latency combinational result and a one-cycle registered copy with load enable. It is used in front of clock-domain-crossing pointers (FIFO read/write pointers) and anywhere a single-bit-change encoding is needed. The combinational path carries no state; only the registered path depends on the clock and reset.

## Interface
- DATA_WIDTH, default 8: width of the binary input and both Gray outputs; legal range ≥ 1.
- clk_i  input  1  clock; the registered path samples on the rising edge.
- arst_ni  input  1  reset, asynchronous and active-low; clears the registered output.
- data_in_i  input  DATA_WIDTH  binary value to convert.
- data_out_o  output  DATA_WIDTH  Gray code of data_in_i, purely combinational.
- en_i  input  1  load enable for the registered output.
- data_q_o  output  DATA_WIDTH  registered Gray code.

## Operation
- Conversion rule:
  - gray[DATA_WIDTH-1] = bin[DATA_WIDTH-1].
  - gray[i] = bin[i] XOR bin[i+1] for i = 0 … DATA_WIDTH-2.
  - Equivalently, gray = bin XOR (bin >> 1), logical shift.
- data_out_o = gray(data_in_i) at all times, independent of clk_i, en_i and arst_ni.
- data_q_o:
  - On each rising clk_i with arst_ni=1 and en_i=1, it loads gray(data_in_i).
  - With en_i=0, it holds its value.
- No arithmetic widening or truncation: output width equals input width.
- DATA_WIDTH=1: output equals input.
- All values 0 … 2^DATA_WIDTH-1 are legal; there are no invalid or X-tolerant codes.
- Adjacent binary values, including the wrap from 2^N-1 to 0, produce Gray codes that differ in exactly one bit.

## Timing
- data_out_o: zero-cycle latency; settles within the same delta/time step as data_in_i (checked 1 time unit after drive).
- data_q_o: one-cycle latency; it reflects data_in_i sampled at the previous enabled rising edge.
- Reset:
  - arst_ni=0 forces data_q_o to all-zeros immediately, without waiting for a clock edge, and holds it there while low.
  - Reset release is synchronous in effect: the first load happens at the first rising edge with arst_ni=1 and en_i=1.
  - Reset asserted mid-operation discards the held value. data_out_o keeps tracking data_in_i throughout reset.
- If en_i and a reset deassertion coincide with the same edge, reset wins for that edge (no load).
- No handshake; there is no backpressure.

## Structure
- No shared package is required; DATA_WIDTH is the only configuration.
- Split into two parts:
  - One natural sub-module, bin_to_gray_comb: parameterised, combinational XOR network, instantiated once. Its output drives data_out_o and the register D input.
  - The top level holds only the enable/async-reset register and the parameter check.
- Add an elaboration-time assertion that DATA_WIDTH ≥ 1.

## Test plan
All cases use DATA_WIDTH=11 unless noted.
- Directed combinational values:
  - 0x000→0x000
  - 0x001→0x001
  - 0x002→0x003
  - 0x555→0x7FF
  - 0x400→0x600
  - 0x7FF→0x400
  - Check each 1 time unit after drive.
- Random/exhaustive: 2048 vectors (random or full sweep 0…2047) compared against gray = bin ^ (bin>>1). Report the pass count as "data conversion pass/total"; the test passes only with zero failures.
- Single-bit-change property: sweep 0…2047 and wrap back to 0. Consecutive data_out_o values must have a Hamming distance of exactly 1.
- Register path:
  - With en_i=1, drive 0x3A5. After the next rising edge, data_q_o = 0x277.
  - With en_i=0, change the input to 0x001. data_q_o stays 0x277 across 3 edges, while data_out_o reads 0x001.
- Async reset: with data_q_o=0x277, pull arst_ni low between edges. data_q_o must read 0x000 before the next edge, while data_out_o still equals gray(data_in_i). After release, the first enabled edge loads normally.
- Width corner: DATA_WIDTH=1, inputs 0→0 and 1→1 on both outputs.
